crc_stream_engine: RTL and testbench

- Parametrised streaming CRC generator/checker for the serial protocol path.
- Sits between the frame byte stream and the UART TX/RX byte interfaces.
- Generate mode forwards the frame and appends the CRC bytes.
- Check mode forwards the frame and flags whether the received CRC is valid.
- Defaults reproduce Modbus RTU CRC-16 (poly 0x8005 reflected, init 0xFFFF).
- Successor to the fixed 16-bit, enable-gated CRC register: adds polynomial/width/reflection generality, valid/ready handshake, CRC append and residue check.

---
 rtl/crc_stream_engine_if.sv | 23 ++
 rtl/crc_stream_engine.sv | 169 ++++++++++++++++
 tb/tb_crc_stream_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_engine_if.sv
// Byte-stream bundle around the CRC engine: input stream (s_*) and output stream (m_*).
interface crc_stream_engine_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    // Environment side: produces the input stream and consumes the output stream.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // Engine side: consumes the input stream and produces the output stream.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker. In generate mode the frame is forwarded and the
// CRC bytes are appended; in check mode the frame is forwarded and crc_ok reports
// whether the raw register landed on the expected residue.
module crc_stream_engine #(
    parameter int          CRC_W   = 16,
    parameter logic [31:0] POLY    = 32'h0000_8005,
    parameter logic [31:0] INIT    = 32'h0000_FFFF,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] XOROUT  = 32'h0000_0000,
    parameter logic [31:0] RESIDUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    crc_stream_engine_if.slave   bus,
    output logic [CRC_W-1:0]     crc_value,
    output logic                 crc_done,
    output logic                 crc_ok
);

    localparam int NB = CRC_W / 8;
    localparam logic [1:0] LAST_IDX = 2'(NB - 1);
    localparam logic [CRC_W-1:0] POLY_T    = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_T    = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_T  = XOROUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RESIDUE_T = RESIDUE[CRC_W-1:0];

    function automatic logic [CRC_W-1:0] reflect_bits(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    localparam logic [CRC_W-1:0] POLY_R = reflect_bits(POLY_T);

    // Whole-byte LFSR update: eight shift steps unrolled into one cycle.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                  input logic [7:0]       b);
        logic [CRC_W-1:0] c;
        c = c_in;
        if (REFLECT) begin
            c[7:0] = c[7:0] ^ b;
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
            end
        end else begin
            c[CRC_W-1 -: 8] = c[CRC_W-1 -: 8] ^ b;
            for (int i = 0; i < 8; i++) begin
                c = c[CRC_W-1] ? ((c << 1) ^ POLY_T) : (c << 1);
            end
        end
        return c;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_APPEND, ST_END} state_t;

    state_t           state, state_next;
    logic [CRC_W-1:0] crc_reg, crc_next, crc_out, crc_shifted;
    logic             mode_q, frame_mode;
    logic             out_free, s_ready_c, accept, load_append, append_last;
    logic             m_valid_q, m_last_q;
    logic [7:0]       m_data_q, append_byte;
    logic [1:0]       app_idx;
    logic [5:0]       append_shift;

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign crc_value   = crc_reg ^ XOROUT_T;

    // Datapath helpers: next CRC for the incoming byte and the CRC byte due for append.
    always_comb begin
        crc_next     = crc_byte(crc_reg, bus.s_data);
        crc_out      = crc_reg ^ XOROUT_T;
        append_shift = REFLECT ? {1'b0, app_idx, 3'b000}
                               : 6'(CRC_W - 8) - {1'b0, app_idx, 3'b000};
        crc_shifted  = crc_out >> append_shift;
        append_byte  = crc_shifted[7:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus handshake: input is taken only when the output register can be refilled.
    always_comb begin
        state_next  = state;
        s_ready_c   = 1'b0;
        accept      = 1'b0;
        load_append = 1'b0;
        append_last = 1'b0;
        out_free    = !m_valid_q || bus.m_ready;
        frame_mode  = (state == ST_IDLE) ? mode : mode_q;
        case (state)
            ST_IDLE, ST_BODY: begin
                s_ready_c = out_free;
                accept    = out_free && bus.s_valid;
                if (accept) begin
                    if (bus.s_last) begin
                        state_next = frame_mode ? ST_END : ST_APPEND;
                    end else begin
                        state_next = ST_BODY;
                    end
                end
            end
            ST_APPEND: begin
                load_append = out_free;
                append_last = (app_idx == LAST_IDX);
                if (load_append && append_last) begin
                    state_next = ST_END;
                end
            end
            ST_END: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // CRC register, output byte register and the completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg   <= INIT_T;
            mode_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            app_idx   <= 2'd0;
            crc_done  <= 1'b0;
            crc_ok    <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            if (accept) begin
                crc_reg   <= crc_next;
                m_valid_q <= 1'b1;
                m_data_q  <= bus.s_data;
                m_last_q  <= frame_mode && bus.s_last;
                if (state == ST_IDLE) begin
                    mode_q <= mode;
                end
            end else if (load_append) begin
                m_valid_q <= 1'b1;
                m_data_q  <= append_byte;
                m_last_q  <= append_last;
                app_idx   <= append_last ? 2'd0 : app_idx + 2'd1;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (state == ST_END) begin
                crc_reg <= INIT_T;
            end
            if (state_next == ST_END) begin
                crc_done <= 1'b1;
                crc_ok   <= frame_mode ? (crc_next == RESIDUE_T) : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench: a Modbus CRC-16 instance and a CRC-32 instance driven with
// directed frames and random frames, compared against a bit-serial division model.
module tb_crc_stream_engine;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_mode = 1'b0;
    logic        tb_s_valid = 1'b0;
    logic        tb_s_last = 1'b0;
    logic [7:0]  tb_s_data = 8'h00;
    logic        tb_m_ready = 1'b1;
    int          cur = 0;
    int          rdy_mode = 0;
    bit          mon_en = 1'b0;
    bit          in_tail = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_bytes[$];
    logic [32:0] exp_done[$];
    logic        last_ok[2];
    logic [31:0] seen_cv;
    logic        seen_ok;

    int          cfg_w[2]    = '{16, 32};
    logic [31:0] cfg_poly[2] = '{32'h0000_8005, 32'h04C1_1DB7};
    logic [31:0] cfg_init[2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] cfg_xor[2]  = '{32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] cfg_res[2]  = '{32'h0000_0000, 32'hDEBB_20E3};
    bit          cfg_refl[2] = '{1'b1, 1'b1};

    crc_stream_engine_if ifa();
    crc_stream_engine_if ifb();

    logic [15:0] crc_a;
    logic [31:0] crc_b;
    logic        done_a, ok_a, done_b, ok_b;

    assign ifa.s_valid = tb_s_valid && (cur == 0);
    assign ifa.s_data  = tb_s_data;
    assign ifa.s_last  = tb_s_last;
    assign ifa.m_ready = tb_m_ready;
    assign ifb.s_valid = tb_s_valid && (cur == 1);
    assign ifb.s_data  = tb_s_data;
    assign ifb.s_last  = tb_s_last;
    assign ifb.m_ready = tb_m_ready;

    crc_stream_engine dut_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (tb_mode),
        .bus       (ifa.slave),
        .crc_value (crc_a),
        .crc_done  (done_a),
        .crc_ok    (ok_a)
    );

    crc_stream_engine #(
        .CRC_W   (32),
        .POLY    (32'h04C1_1DB7),
        .INIT    (32'hFFFF_FFFF),
        .REFLECT (1'b1),
        .XOROUT  (32'hFFFF_FFFF),
        .RESIDUE (32'hDEBB_20E3)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (tb_mode),
        .bus       (ifb.slave),
        .crc_value (crc_b),
        .crc_done  (done_b),
        .crc_ok    (ok_b)
    );

    always #5 clk = ~clk;

    // View of whichever instance is currently under test.
    logic        sr, mv, ml, dn, ok;
    logic [7:0]  md;
    logic [31:0] cv;
    always_comb begin
        if (cur == 0) begin
            sr = ifa.s_ready; mv = ifa.m_valid; ml = ifa.m_last; md = ifa.m_data;
            dn = done_a; ok = ok_a; cv = {16'h0000, crc_a};
        end else begin
            sr = ifb.s_ready; mv = ifb.m_valid; ml = ifb.m_last; md = ifb.m_data;
            dn = done_b; ok = ok_b; cv = crc_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [31:0] rev_bits(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Polynomial division of the transmitted bit stream; result in the engine's register orientation.
    function automatic logic [31:0] model_raw(input int sel, input byte_q_t msg);
        int          w;
        logic [31:0] mask, rv;
        logic        bitv, top;
        w    = cfg_w[sel];
        mask = wmask(w);
        rv   = cfg_refl[sel] ? rev_bits(cfg_init[sel] & mask, w) : (cfg_init[sel] & mask);
        foreach (msg[k]) begin
            for (int j = 0; j < 8; j++) begin
                bitv = cfg_refl[sel] ? msg[k][j] : msg[k][7-j];
                top  = rv[w-1] ^ bitv;
                rv   = (rv << 1) & mask;
                if (top) rv = rv ^ (cfg_poly[sel] & mask);
            end
        end
        return cfg_refl[sel] ? rev_bits(rv, w) : rv;
    endfunction

    function automatic byte_q_t crc_bytes(input int sel, input byte_q_t msg);
        byte_q_t     q;
        logic [31:0] c;
        int          nb, sh;
        c  = (model_raw(sel, msg) ^ cfg_xor[sel]) & wmask(cfg_w[sel]);
        nb = cfg_w[sel] / 8;
        q  = {};
        for (int k = 0; k < nb; k++) begin
            sh = cfg_refl[sel] ? 8 * k : 8 * (nb - 1 - k);
            q.push_back(c[sh +: 8]);
        end
        return q;
    endfunction

    // Ready pattern for the output side: steady, toggling or random.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       tb_m_ready = 1'b1;
                1:       tb_m_ready = !tb_m_ready;
                default: tb_m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: consumes expected bytes and completions as they occur.
    always @(negedge clk) begin
        logic [8:0]  eb;
        logic [32:0] ed;
        #2;
        if (mon_en) begin
            if (in_tail) checkOutput("s_ready_tail", 32'(sr), 32'd0);
            if (mv && tb_m_ready) begin
                if (exp_bytes.size() == 0) begin
                    checkOutput("extra_byte", 32'(exp_bytes.size()), 32'd1);
                end else begin
                    eb = exp_bytes.pop_front();
                    checkOutput("m_data", 32'(md), 32'(eb[7:0]));
                    checkOutput("m_last", 32'(ml), 32'(eb[8]));
                end
            end
            if (dn) begin
                if (exp_done.size() == 0) begin
                    checkOutput("extra_done", 32'(exp_done.size()), 32'd1);
                end else begin
                    ed = exp_done.pop_front();
                    checkOutput("crc_ok", 32'(ok), 32'(ed[32]));
                    checkOutput("crc_value", cv, ed[31:0]);
                    last_ok[cur] = ed[32];
                end
                seen_cv = cv;
                seen_ok = ok;
                in_tail = 1'b0;
            end else begin
                checkOutput("crc_ok_hold", 32'(ok), 32'(last_ok[cur]));
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic last);
        int budget;
        budget = 0;
        @(negedge clk);
        tb_s_valid = 1'b1;
        tb_s_data  = d;
        tb_s_last  = last;
        #1;
        while (!sr && budget < 300) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!sr) begin
            checkOutput("s_ready_timeout", 32'(sr), 32'd1);
            tb_s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (last) in_tail = 1'b1;
        #1;
        tb_s_valid = 1'b0;
    endtask

    // Drives one frame and queues the model's expected output and completion.
    task automatic applyStimulus(input byte_q_t msg, input logic mdv, input bit flip_mode);
        logic [31:0] raw, mask;
        byte_q_t     cb;
        int          budget;
        mask = wmask(cfg_w[cur]);
        raw  = model_raw(cur, msg);
        foreach (msg[i]) exp_bytes.push_back({mdv && (i == msg.size() - 1), msg[i]});
        if (!mdv) begin
            cb = crc_bytes(cur, msg);
            foreach (cb[k]) exp_bytes.push_back({k == cb.size() - 1, cb[k]});
        end
        exp_done.push_back({mdv ? (raw == (cfg_res[cur] & mask)) : 1'b1, (raw ^ cfg_xor[cur]) & mask});
        tb_mode = mdv;
        foreach (msg[i]) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            push_byte(msg[i], i == msg.size() - 1);
            if (i == 0 && flip_mode) tb_mode = !mdv;
        end
        budget = 0;
        while ((exp_bytes.size() != 0 || exp_done.size() != 0) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (exp_bytes.size() != 0 || exp_done.size() != 0) begin
            checkOutput("frame_timeout", 32'(exp_bytes.size() + exp_done.size()), 32'd0);
            exp_bytes = {};
            exp_done  = {};
            in_tail   = 1'b0;
        end
    endtask

    task automatic random_frames(input int n);
        byte_q_t msg, cb;
        logic    mdv;
        int      len, idx;
        for (int f = 0; f < n; f++) begin
            len = $urandom_range(1, 10);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            mdv = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 2);
            if (mdv) begin
                cb = crc_bytes(cur, msg);
                foreach (cb[k]) msg.push_back(cb[k]);
                if ($urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, msg.size() - 1);
                    msg[idx] = msg[idx] ^ 8'($urandom_range(1, 255));
                end
            end
            applyStimulus(msg, mdv, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_q_t digits, msg;
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        last_ok[0] = 1'b0;
        last_ok[1] = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_a_m_valid", 32'(ifa.m_valid), 32'd0);
        checkOutput("rst_a_m_data", 32'(ifa.m_data), 32'd0);
        checkOutput("rst_a_m_last", 32'(ifa.m_last), 32'd0);
        checkOutput("rst_a_done", 32'(done_a), 32'd0);
        checkOutput("rst_a_ok", 32'(ok_a), 32'd0);
        checkOutput("rst_a_crc_value", 32'(crc_a), 32'h0000_FFFF);
        checkOutput("rst_b_m_valid", 32'(ifb.m_valid), 32'd0);
        checkOutput("rst_b_done", 32'(done_b), 32'd0);
        checkOutput("rst_b_ok", 32'(ok_b), 32'd0);
        checkOutput("rst_b_crc_value", crc_b, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        cur = 0;
        rdy_mode = 0;
        applyStimulus(digits, 1'b0, 1'b0);
        checkOutput("gen_modbus_crc", seen_cv, 32'h0000_4B37);
        checkOutput("gen_modbus_ok", 32'(seen_ok), 32'd1);

        msg = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        applyStimulus(msg, 1'b1, 1'b0);
        checkOutput("chk_modbus_ok", 32'(seen_ok), 32'd1);
        checkOutput("chk_modbus_raw", seen_cv, 32'h0000_0000);

        msg[7] = 8'hCC;
        applyStimulus(msg, 1'b1, 1'b1);
        checkOutput("chk_modbus_bad", 32'(seen_ok), 32'd0);
        repeat (5) @(negedge clk);

        rdy_mode = 1;
        applyStimulus(digits, 1'b0, 1'b1);
        checkOutput("bp_modbus_crc", seen_cv, 32'h0000_4B37);

        mon_en = 1'b0;
        rdy_mode = 0;
        tb_mode = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(digits[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("midrst_m_valid", 32'(ifa.m_valid), 32'd0);
        checkOutput("midrst_crc_value", 32'(crc_a), 32'h0000_FFFF);
        @(negedge clk);
        rst = 1'b0;
        last_ok[0] = 1'b0;
        last_ok[1] = 1'b0;
        in_tail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            checkOutput("midrst_no_done", 32'(done_a), 32'd0);
        end
        mon_en = 1'b1;
        msg = '{8'h01};
        applyStimulus(msg, 1'b0, 1'b0);
        checkOutput("one_byte_crc", seen_cv, 32'h0000_807E);

        random_frames(25);

        cur = 1;
        rdy_mode = 0;
        applyStimulus(digits, 1'b0, 1'b0);
        checkOutput("gen_crc32", seen_cv, 32'hCBF4_3926);
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        rdy_mode = 2;
        applyStimulus(msg, 1'b1, 1'b0);
        checkOutput("chk_crc32_ok", 32'(seen_ok), 32'd1);
        random_frames(15);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
